// File: rtl/quadrilatero_pkg.sv
// Shared types for the quadrilatero matrix register-file write path:
// write-port beat layout, arbiter state encoding and pointer arithmetic.
package quadrilatero_pkg;

    localparam int QL_RLEN   = 128;
    localparam int QL_N_REGS = 8;
    localparam int QL_N_ROWS = 4;
    localparam int QL_REG_AW = $clog2(QL_N_REGS);
    localparam int QL_ROW_AW = $clog2(QL_N_ROWS);

    typedef struct packed {
        logic [QL_REG_AW-1:0] waddr;
        logic [QL_ROW_AW-1:0] wrowaddr;
        logic [QL_RLEN-1:0]   wdata;
        logic                 wlast;
    } wport_req_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } wport_state_e;

    // Round-robin successor: n-1 wraps back to 0.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/quadrilatero_rr_picker.sv
// Rotating-priority encoder: first set request at or after ptr_i (mod N_REQ).
// Purely combinational; valid_o low when no request is set.
module quadrilatero_rr_picker #(
    parameter int N_REQ = 3,
    localparam int PW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    output logic [PW-1:0]    grant_o,
    output logic             valid_o
);

    int idx;

    // Scan farthest offset first so the nearest requester after ptr_i wins.
    always_comb begin
        grant_o = ptr_i;
        valid_o = 1'b0;
        idx     = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_i) + k) % N_REQ;
            if (req_i[idx]) begin
                grant_o = PW'(idx);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/quadrilatero_wport_arbiter.sv
// Burst-locking round-robin arbiter for the matrix register-file write port.
// A winner keeps the port until its wlast beat is accepted; data passes through untouched.
module quadrilatero_wport_arbiter
    import quadrilatero_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int RLEN   = QL_RLEN,
    parameter int N_REGS = QL_N_REGS,
    parameter int N_ROWS = QL_N_ROWS,
    localparam int AW    = $clog2(N_REGS),
    localparam int RW    = $clog2(N_ROWS),
    localparam int PW    = $clog2(N_REQ)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [N_REQ*AW-1:0] req_waddr_i,
    input  logic [N_REQ*RW-1:0] req_wrowaddr_i,
    input  logic [N_REQ*RLEN-1:0] req_wdata_i,
    input  logic [N_REQ-1:0]    req_we_i,
    input  logic [N_REQ-1:0]    req_wlast_i,
    output logic [N_REQ-1:0]    req_wready_o,
    output logic [AW-1:0]       waddr_o,
    output logic [RW-1:0]       wrowaddr_o,
    output logic [RLEN-1:0]     wdata_o,
    output logic                we_o,
    output logic                wlast_o,
    input  logic                wready_i,
    output logic                locked_o,
    output logic [PW-1:0]       owner_o
);

    if (N_REQ < 2) begin : g_bad_nreq
        $error("quadrilatero_wport_arbiter: N_REQ must be at least 2");
    end
    // The beat struct is sized by the package geometry, so the instance must match it.
    if (RLEN != QL_RLEN || N_REGS != QL_N_REGS || N_ROWS != QL_N_ROWS) begin : g_bad_geom
        $error("quadrilatero_wport_arbiter: geometry differs from quadrilatero_pkg");
    end

    wport_state_e   state_q, state_d;
    logic [PW-1:0]  owner_q, owner_d;
    logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]  pick_idx;
    logic           pick_valid;
    logic [PW-1:0]  sel;
    logic           active;
    logic           accept;
    wport_req_t     beat;

    quadrilatero_rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req_i   (req_we_i),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_idx),
        .valid_o (pick_valid)
    );

    // While locked only the owner is forwarded, even when it has nothing to write.
    always_comb begin
        sel          = (state_q == LOCKED) ? owner_q : pick_idx;
        active       = (state_q == LOCKED) ? req_we_i[sel] : pick_valid;
        beat         = '0;
        req_wready_o = '0;
        if (active) begin
            beat.waddr       = req_waddr_i[int'(sel)*AW +: AW];
            beat.wrowaddr    = req_wrowaddr_i[int'(sel)*RW +: RW];
            beat.wdata       = req_wdata_i[int'(sel)*RLEN +: RLEN];
            beat.wlast       = req_wlast_i[sel];
            req_wready_o[sel] = wready_i;
        end
    end

    assign we_o       = active;
    assign waddr_o    = beat.waddr;
    assign wrowaddr_o = beat.wrowaddr;
    assign wdata_o    = beat.wdata;
    assign wlast_o    = beat.wlast;
    assign accept     = active & wready_i;
    assign locked_o   = (state_q == LOCKED);
    assign owner_o    = (state_q == LOCKED) ? owner_q : (pick_valid ? pick_idx : rr_ptr_q);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (beat.wlast) begin
                        rr_ptr_d = PW'(wrap_inc(int'(pick_idx), N_REQ));
                    end else begin
                        state_d = LOCKED;
                        owner_d = pick_idx;
                    end
                end
            end
            LOCKED: begin
                if (accept && beat.wlast) begin
                    state_d  = IDLE;
                    rr_ptr_d = PW'(wrap_inc(int'(owner_q), N_REQ));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_quadrilatero_wport_arbiter.sv
// Self-checking bench for quadrilatero_wport_arbiter: directed scenarios plus
// randomized burst traffic compared against a behavioural arbitration model.
module tb_quadrilatero_wport_arbiter;

    localparam int N  = 3;
    localparam int AW = 3;
    localparam int RW = 2;
    localparam int DW = 128;
    localparam int PW = 2;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [N*AW-1:0]   req_waddr;
    logic [N*RW-1:0]   req_wrow;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      req_we;
    logic [N-1:0]      req_wlast;
    logic [N-1:0]      req_wready;
    logic [AW-1:0]     waddr_o;
    logic [RW-1:0]     wrowaddr_o;
    logic [DW-1:0]     wdata_o;
    logic              we_o;
    logic              wlast_o;
    logic              wready;
    logic              locked_o;
    logic [PW-1:0]     owner_o;

    int errors = 0;
    int checks = 0;

    // Behavioural model: lock owner (-1 when free) and round-robin start point.
    int            m_owner;
    int            m_ptr;
    logic          exp_we, exp_locked, exp_wlast;
    int            exp_sel;
    logic [PW-1:0] exp_owner;
    logic [N-1:0]  exp_ready;
    logic [AW-1:0] exp_waddr;
    logic [RW-1:0] exp_wrow;
    logic [DW-1:0] exp_wdata;

    always #5 clk_i = ~clk_i;

    quadrilatero_wport_arbiter dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_waddr_i    (req_waddr),
        .req_wrowaddr_i (req_wrow),
        .req_wdata_i    (req_wdata),
        .req_we_i       (req_we),
        .req_wlast_i    (req_wlast),
        .req_wready_o   (req_wready),
        .waddr_o        (waddr_o),
        .wrowaddr_o     (wrowaddr_o),
        .wdata_o        (wdata_o),
        .we_o           (we_o),
        .wlast_o        (wlast_o),
        .wready_i       (wready),
        .locked_o       (locked_o),
        .owner_o        (owner_o)
    );

    function automatic logic [DW-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic void model_eval();
        int idx;
        exp_we     = 1'b0;
        exp_sel    = -1;
        exp_locked = (m_owner >= 0);
        exp_owner  = PW'(m_ptr);
        if (m_owner >= 0) begin
            exp_sel   = m_owner;
            exp_owner = PW'(m_owner);
            exp_we    = req_we[m_owner];
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (exp_sel < 0 && req_we[idx]) exp_sel = idx;
            end
            if (exp_sel >= 0) begin
                exp_we    = 1'b1;
                exp_owner = PW'(exp_sel);
            end
        end
        exp_ready = '0;
        exp_waddr = '0;
        exp_wrow  = '0;
        exp_wdata = '0;
        exp_wlast = 1'b0;
        if (exp_we) begin
            exp_ready[exp_sel] = wready;
            exp_waddr = req_waddr[exp_sel*AW +: AW];
            exp_wrow  = req_wrow[exp_sel*RW +: RW];
            exp_wdata = req_wdata[exp_sel*DW +: DW];
            exp_wlast = req_wlast[exp_sel];
        end
    endfunction

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                           input logic [RW-1:0] r, input logic [DW-1:0] d, input logic last);
        req_we[i]             = we;
        req_waddr[i*AW +: AW] = a;
        req_wrow[i*RW +: RW]  = r;
        req_wdata[i*DW +: DW] = d;
        req_wlast[i]          = last;
    endtask

    task automatic clear_all();
        req_we    = '0;
        req_waddr = '0;
        req_wrow  = '0;
        req_wdata = '0;
        req_wlast = '0;
    endtask

    // Advance one clock, applying the model's rules for the beat presented this cycle.
    task automatic tick();
        model_eval();
        if (!rst_ni) begin
            m_owner = -1;
            m_ptr   = 0;
        end else if (exp_we && wready) begin
            if (exp_wlast) begin
                m_owner = -1;
                m_ptr   = (exp_sel + 1) % N;
            end else begin
                m_owner = exp_sel;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        clear_all();
        rst_ni  = 1'b0;
        m_owner = -1;
        m_ptr   = 0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        clear_all();
        wready  = 1'b1;
        rst_ni  = 1'b0;
        m_owner = -1;
        m_ptr   = 0;
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if ({locked_o, we_o, wlast_o, owner_o, req_wready} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: locked=%0b we=%0b wlast=%0b owner=%0d ready=%b, want all 0",
                     locked_o, we_o, wlast_o, owner_o, req_wready);
        end
        checks++;
        if ({waddr_o, wrowaddr_o, wdata_o} !== '0) begin
            errors++;
            $display("FAIL reset_data: waddr=%0h row=%0h data=%0h, want 0", waddr_o, wrowaddr_o, wdata_o);
        end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_single_burst();
        logic [DW-1:0] d;
        wready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            d = rand_data();
            set_req(1, 1'b1, 3'd5, RW'(b), d, b == 3);
            #1;
            checks++;
            if ({we_o, waddr_o, wrowaddr_o, wdata_o, req_wready} !== {1'b1, 3'd5, RW'(b), d, 3'b010}) begin
                errors++;
                $display("FAIL single_beat%0d: we=%0b reg=%0d row=%0d ready=%b data=%0h, want we=1 reg=5 row=%0d ready=010 data=%0h",
                         b, we_o, waddr_o, wrowaddr_o, req_wready, wdata_o, b, d);
            end
            checks++;
            if (locked_o !== (b != 0)) begin
                errors++;
                $display("FAIL single_lock%0d: locked=%0b want %0b", b, locked_o, b != 0);
            end
            tick();
        end
        clear_all();
        #1;
        checks++;
        if (locked_o !== 1'b0 || owner_o !== 2'd2 || we_o !== 1'b0) begin
            errors++;
            $display("FAIL single_end: locked=%0b owner=%0d we=%0b, want locked=0 owner=2 we=0",
                     locked_o, owner_o, we_o);
        end
    endtask

    task automatic test_two_contend();
        int            cnt [N];
        logic [DW-1:0] dat [N];
        int            log_own[$];
        int            log_row[$];
        do_reset();
        wready = 1'b1;
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            dat[i] = rand_data();
        end
        for (int cyc = 0; cyc < 20 && (cnt[0] < 4 || cnt[2] < 4); cyc++) begin
            set_req(0, cnt[0] < 4, 3'd1, RW'(cnt[0]), dat[0], cnt[0] == 3);
            set_req(1, 1'b0, '0, '0, '0, 1'b0);
            set_req(2, cnt[2] < 4, 3'd6, RW'(cnt[2]), dat[2], cnt[2] == 3);
            #1;
            model_eval();
            checks++;
            if ({we_o, owner_o, wrowaddr_o, wdata_o} !== {exp_we, exp_owner, exp_wrow, exp_wdata}) begin
                errors++;
                $display("FAIL contend_cyc%0d: we=%0b owner=%0d row=%0d, want we=%0b owner=%0d row=%0d",
                         cyc, we_o, owner_o, wrowaddr_o, exp_we, exp_owner, exp_wrow);
            end
            if (we_o && wready) begin
                log_own.push_back(int'(owner_o));
                log_row.push_back(int'(wrowaddr_o));
            end
            for (int i = 0; i < N; i++) begin
                if (req_wready[i] && req_we[i]) begin
                    cnt[i]++;
                    dat[i] = rand_data();
                end
            end
            tick();
        end
        clear_all();
        checks++;
        if (log_own.size() != 8) begin
            errors++;
            $display("FAIL contend_count: beats=%0d want 8", log_own.size());
        end else begin
            for (int j = 0; j < 8; j++) begin
                checks++;
                if (log_own[j] != (j < 4 ? 0 : 2) || log_row[j] != j % 4) begin
                    errors++;
                    $display("FAIL contend_order%0d: owner=%0d row=%0d, want owner=%0d row=%0d",
                             j, log_own[j], log_row[j], (j < 4 ? 0 : 2), j % 4);
                end
            end
        end
    endtask

    task automatic test_we_drop();
        logic [DW-1:0] d1;
        wready = 1'b1;
        d1 = rand_data();
        set_req(1, 1'b1, 3'd2, 2'd0, d1, 1'b1);
        for (int b = 0; b < 2; b++) begin
            set_req(0, 1'b1, 3'd3, RW'(b), rand_data(), 1'b0);
            #1;
            checks++;
            if (owner_o !== 2'd0 || wrowaddr_o !== RW'(b) || we_o !== 1'b1) begin
                errors++;
                $display("FAIL drop_pre%0d: owner=%0d row=%0d we=%0b, want owner=0 row=%0d we=1",
                         b, owner_o, wrowaddr_o, we_o, b);
            end
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            set_req(0, 1'b0, '0, '0, '0, 1'b0);
            #1;
            checks++;
            if (we_o !== 1'b0 || req_wready !== 3'b000 || locked_o !== 1'b1 || wdata_o !== '0 || owner_o !== 2'd0) begin
                errors++;
                $display("FAIL drop_gap%0d: we=%0b ready=%b locked=%0b owner=%0d data=%0h, want we=0 ready=000 locked=1 owner=0 data=0",
                         c, we_o, req_wready, locked_o, owner_o, wdata_o);
            end
            tick();
        end
        for (int b = 2; b < 4; b++) begin
            set_req(0, 1'b1, 3'd3, RW'(b), rand_data(), b == 3);
            #1;
            checks++;
            if (wrowaddr_o !== RW'(b) || owner_o !== 2'd0 || req_wready !== 3'b001) begin
                errors++;
                $display("FAIL drop_resume%0d: row=%0d owner=%0d ready=%b, want row=%0d owner=0 ready=001",
                         b, wrowaddr_o, owner_o, req_wready, b);
            end
            tick();
        end
        set_req(0, 1'b0, '0, '0, '0, 1'b0);
        #1;
        checks++;
        if (owner_o !== 2'd1 || we_o !== 1'b1 || waddr_o !== 3'd2 || wdata_o !== d1 || req_wready !== 3'b010) begin
            errors++;
            $display("FAIL drop_next: owner=%0d we=%0b reg=%0d ready=%b, want owner=1 we=1 reg=2 ready=010",
                     owner_o, we_o, waddr_o, req_wready);
        end
        tick();
        clear_all();
    endtask

    task automatic test_wready_stall();
        set_req(2, 1'b1, 3'd4, 2'd0, rand_data(), 1'b0);
        wready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (we_o !== 1'b1 || locked_o !== 1'b0 || req_wready !== 3'b000 || owner_o !== 2'd2) begin
                errors++;
                $display("FAIL stall%0d: we=%0b locked=%0b ready=%b owner=%0d, want we=1 locked=0 ready=000 owner=2",
                         c, we_o, locked_o, req_wready, owner_o);
            end
            tick();
        end
        wready = 1'b1;
        #1;
        checks++;
        if (req_wready !== 3'b100) begin
            errors++;
            $display("FAIL stall_release: ready=%b want 100", req_wready);
        end
        tick();
        for (int b = 1; b < 4; b++) begin
            set_req(2, 1'b1, 3'd4, RW'(b), rand_data(), b == 3);
            #1;
            checks++;
            if (locked_o !== 1'b1 || wrowaddr_o !== RW'(b)) begin
                errors++;
                $display("FAIL stall_burst%0d: locked=%0b row=%0d, want locked=1 row=%0d", b, locked_o, wrowaddr_o, b);
            end
            tick();
        end
        clear_all();
    endtask

    task automatic test_round_robin();
        int            rr_exp [4] = '{0, 1, 2, 0};
        logic [DW-1:0] dat [N];
        wready = 1'b1;
        for (int i = 0; i < N; i++) dat[i] = rand_data();
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i), 2'd0, dat[i], 1'b1);
            #1;
            checks++;
            if (owner_o !== PW'(rr_exp[c]) || req_wready !== N'(1 << rr_exp[c]) || wdata_o !== dat[rr_exp[c]] || locked_o !== 1'b0) begin
                errors++;
                $display("FAIL rr%0d: owner=%0d ready=%b locked=%0b, want owner=%0d ready=%b locked=0",
                         c, owner_o, req_wready, locked_o, rr_exp[c], N'(1 << rr_exp[c]));
            end
            dat[rr_exp[c]] = rand_data();
            tick();
        end
        clear_all();
    endtask

    task automatic test_reset_mid_burst();
        wready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            set_req(0, 1'b1, 3'd2, RW'(b), rand_data(), 1'b0);
            tick();
        end
        #1;
        checks++;
        if (locked_o !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: locked=%0b want 1", locked_o);
        end
        clear_all();
        rst_ni  = 1'b0;
        m_owner = -1;
        m_ptr   = 0;
        #1;
        checks++;
        if ({locked_o, we_o, wlast_o, owner_o, req_wready, waddr_o, wrowaddr_o, wdata_o} !== '0) begin
            errors++;
            $display("FAIL midrst_async: locked=%0b we=%0b owner=%0d data=%0h, want all 0",
                     locked_o, we_o, owner_o, wdata_o);
        end
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        #1;
        checks++;
        if (locked_o !== 1'b0 || owner_o !== 2'd0) begin
            errors++;
            $display("FAIL midrst_after: locked=%0b owner=%0d, want locked=0 owner=0", locked_o, owner_o);
        end
        tick();
    endtask

    task automatic test_random();
        int            len [N];
        int            beat [N];
        logic          busy [N];
        logic          we_on [N];
        logic [AW-1:0] raddr [N];
        logic [DW-1:0] dat [N];
        for (int i = 0; i < N; i++) begin
            busy[i]  = 1'b0;
            we_on[i] = 1'b0;
            len[i]   = 0;
            beat[i]  = 0;
            raddr[i] = '0;
            dat[i]   = '0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!busy[i] && $urandom_range(2) == 0) begin
                    busy[i]  = 1'b1;
                    len[i]   = 1 + int'($urandom_range(3));
                    beat[i]  = 0;
                    raddr[i] = AW'($urandom);
                    dat[i]   = rand_data();
                end
                if (busy[i] && !we_on[i]) we_on[i] = ($urandom_range(3) != 0);
                set_req(i, busy[i] && we_on[i], raddr[i], RW'(beat[i]), dat[i], beat[i] == len[i] - 1);
            end
            wready = ($urandom_range(3) != 0);
            #1;
            model_eval();
            checks++;
            if ({we_o, locked_o, owner_o, req_wready, wlast_o} !== {exp_we, exp_locked, exp_owner, exp_ready, exp_wlast}) begin
                errors++;
                $display("FAIL rand_ctrl%0d: we=%0b locked=%0b owner=%0d ready=%b wlast=%0b, want we=%0b locked=%0b owner=%0d ready=%b wlast=%0b",
                         cyc, we_o, locked_o, owner_o, req_wready, wlast_o,
                         exp_we, exp_locked, exp_owner, exp_ready, exp_wlast);
            end
            checks++;
            if ({waddr_o, wrowaddr_o, wdata_o} !== {exp_waddr, exp_wrow, exp_wdata}) begin
                errors++;
                $display("FAIL rand_data%0d: reg=%0d row=%0d data=%0h, want reg=%0d row=%0d data=%0h",
                         cyc, waddr_o, wrowaddr_o, wdata_o, exp_waddr, exp_wrow, exp_wdata);
            end
            for (int i = 0; i < N; i++) begin
                if (req_wready[i] && req_we[i]) begin
                    beat[i]++;
                    dat[i]   = rand_data();
                    we_on[i] = ($urandom_range(3) != 0);
                    if (beat[i] == len[i]) begin
                        busy[i]  = 1'b0;
                        we_on[i] = 1'b0;
                    end
                end
            end
            tick();
        end
        clear_all();
    endtask

    initial begin
        clear_all();
        wready  = 1'b0;
        rst_ni  = 1'b0;
        m_owner = -1;
        m_ptr   = 0;
        test_reset();
        test_single_burst();
        test_two_contend();
        test_we_drop();
        test_wready_stall();
        test_round_robin();
        test_reset_mid_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
